// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   ST_*        : FSM state encoding (IDLE/RUN/DONE)
//   DEF_N_WIDTH : default dividend/quotient width
//   DEF_D_WIDTH : default divisor/remainder width
//   CNT_WIDTH   : step counter width (one count per quotient bit)
package divider_pkg;

    localparam int DEF_N_WIDTH = 32;
    localparam int DEF_D_WIDTH = 16;
    localparam int CNT_WIDTH   = $clog2(DEF_N_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step, purely combinational.
//   rem_i   : current partial remainder (D_WIDTH+1 bits, always < divisor)
//   bit_i   : next dividend bit, MSB first
//   div_i   : divisor
//   rem_o   : partial remainder after the step
//   q_bit_o : quotient bit produced by this step
module div_step
    import divider_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH
) (
    input  logic [D_WIDTH:0]   rem_i,
    input  logic               bit_i,
    input  logic [D_WIDTH-1:0] div_i,
    output logic [D_WIDTH:0]   rem_o,
    output logic               q_bit_o
);

    logic [D_WIDTH+1:0] shifted;
    logic [D_WIDTH+1:0] trial;
    logic               neg;

    // shifted < 2*divisor, so the top bit of the trial difference is a
    // reliable sign: set only when the subtraction wrapped.
    assign shifted = {rem_i, bit_i};
    assign trial   = shifted - {2'b00, div_i};
    assign neg     = trial[D_WIDTH+1];

    assign q_bit_o = ~neg;
    assign rem_o   = neg ? shifted[D_WIDTH:0] : trial[D_WIDTH:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk, rst     : clock and synchronous active-high reset
//   start        : begin a division (only looked at in IDLE)
//   dividend     : N_WIDTH-bit unsigned dividend, captured on accept
//   divisor      : D_WIDTH-bit unsigned divisor, captured on accept
//   busy         : high from the cycle after accept until done
//   done         : one-cycle pulse, results valid
//   quotient     : N_WIDTH-bit result, held until the next done
//   remainder    : D_WIDTH-bit result, held until the next done
//   div_by_zero  : captured divisor was zero (quotient all ones,
//                  remainder = low dividend bits)
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; results from the last operation held
// RUN     | one restoring step per cycle, N_WIDTH cycles
// DONE    | publish results, pulse done, back to IDLE
module seq_restoring_divider
    import divider_pkg::*;
#(
    parameter int N_WIDTH = DEF_N_WIDTH,
    parameter int D_WIDTH = DEF_D_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_WIDTH-1:0] dividend,
    input  logic [D_WIDTH-1:0] divisor,
    output logic               busy,
    output logic               done,
    output logic [N_WIDTH-1:0] quotient,
    output logic [D_WIDTH-1:0] remainder,
    output logic               div_by_zero
);

    localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(N_WIDTH - 1);

    div_state_t         state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    // Dividend bits shift out of the top while quotient bits shift in at
    // the bottom; after N_WIDTH steps this register holds the quotient.
    logic [N_WIDTH-1:0] dq_q;
    logic [D_WIDTH-1:0] div_q;
    logic [D_WIDTH:0]   rem_q;
    logic               dz_q;
    logic               busy_q;
    logic               done_q;
    logic [N_WIDTH-1:0] quot_q;
    logic [D_WIDTH-1:0] remd_q;
    logic               dzo_q;

    logic [D_WIDTH:0]   rem_d;
    logic               q_bit_d;

    div_step #(
        .D_WIDTH (D_WIDTH)
    ) u_step (
        .rem_i   (rem_q),
        .bit_i   (dq_q[N_WIDTH-1]),
        .div_i   (div_q),
        .rem_o   (rem_d),
        .q_bit_o (q_bit_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dq_q    <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            remd_q  <= '0;
            dzo_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        dq_q    <= dividend;
                        div_q   <= divisor;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        dz_q    <= (divisor == '0);
                        busy_q  <= 1'b1;
                        state_q <= (divisor == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    dq_q  <= {dq_q[N_WIDTH-2:0], q_bit_d};
                    rem_q <= rem_d;
                    if (cnt_q == LAST_STEP) begin
                        cnt_q   <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    dzo_q   <= dz_q;
                    // On divide by zero dq_q still holds the untouched dividend.
                    quot_q  <= dz_q ? '1 : dq_q;
                    remd_q  <= dz_q ? dq_q[D_WIDTH-1:0] : rem_q[D_WIDTH-1:0];
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = remd_q;
    assign div_by_zero = dzo_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int n_checks;
    int n_errors;

    seq_restoring_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue start (accepted on the next rising edge), then count edges until
    // done is seen. Samples are taken 1 time unit after each rising edge.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [15:0] b,
                          input logic [31:0] exp_q, input logic [15:0] exp_r,
                          input logic exp_dz, input int exp_lat);
        int lat;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        check({tag, " busy"}, 64'(busy), 64'(1));
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " quotient"}, 64'(quotient), 64'(exp_q));
        check({tag, " remainder"}, 64'(remainder), 64'(exp_r));
        check({tag, " dz"}, 64'(div_by_zero), 64'(exp_dz));
        check({tag, " busy at done"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int lat;
        int seen_done;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset quotient", 64'(quotient), 64'(0));
        check("reset remainder", 64'(remainder), 64'(0));
        check("reset dz", 64'(div_by_zero), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        do_div("75/5", 32'd75, 16'd5, 32'd15, 16'd0, 1'b0, 33);

        // Back-to-back chain: each call raises start in the IDLE cycle with done high.
        do_div("1000000/1000", 32'd1000000, 16'd1000, 32'd1000, 16'd0, 1'b0, 33);
        do_div("959904/9999", 32'd959904, 16'd9999, 32'd96, 16'd0, 1'b0, 33);
        do_div("256000/250", 32'd256000, 16'd250, 32'd1024, 16'd0, 1'b0, 33);
        do_div("3322/255", 32'd3322, 16'd255, 32'd13, 16'd7, 1'b0, 33);

        // Results hold after the done pulse.
        @(posedge clk);
        #1;
        check("done one cycle", 64'(done), 64'(0));
        check("hold quotient", 64'(quotient), 64'(13));
        check("hold remainder", 64'(remainder), 64'(7));

        do_div("max/1", 32'hFFFF_FFFF, 16'd1, 32'hFFFF_FFFF, 16'd0, 1'b0, 33);
        do_div("max/ffff", 32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'd0, 1'b0, 33);
        do_div("5/7", 32'd5, 16'd7, 32'd0, 16'd5, 1'b0, 33);

        // Start pulse during RUN with new operands must be ignored.
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        repeat (9) begin
            @(posedge clk);
            lat++;
        end
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 16'd5;
        @(posedge clk);
        #1;
        lat++;
        start = 1'b0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("ignore latency", 64'(lat), 64'(33));
        check("ignore quotient", 64'(quotient), 64'(333));
        check("ignore remainder", 64'(remainder), 64'(1));
        @(posedge clk);
        #1;
        check("ignore no restart", 64'(busy), 64'(0));

        do_div("1234/0", 32'd1234, 16'd0, 32'hFFFF_FFFF, 16'd1234, 1'b1, 1);

        // Reset in the middle of RUN.
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd100000;
        divisor  = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrun rst busy", 64'(busy), 64'(0));
        check("midrun rst done", 64'(done), 64'(0));
        check("midrun rst quotient", 64'(quotient), 64'(0));
        check("midrun rst remainder", 64'(remainder), 64'(0));
        check("midrun rst dz", 64'(div_by_zero), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        check("no done after rst", 64'(seen_done), 64'(0));

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 32'd77;
        divisor  = 16'd7;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("rst over start busy", 64'(busy), 64'(0));

        do_div("100/7", 32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 33);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_restoring_divider.md
SEQ_RESTORING_DIVIDER -- requirements
Module: seq_restoring_divider

Interface
REQ-001 SHALL provide parameter N_WIDTH, 32, dividend and quotient width.
REQ-002 SHALL provide parameter D_WIDTH, 16, divisor and remainder width.
REQ-003 SHALL have one clock and a synchronous, active-high reset; the ports are clk and rst.
REQ-004 SHALL have clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have rst  input  1  synchronous active-high reset.
REQ-006 SHALL have start  input  1  request to begin a division; sampled only in IDLE.
REQ-007 SHALL have dividend  input  N_WIDTH  unsigned dividend, captured when start is accepted.
REQ-008 SHALL have divisor  input  D_WIDTH  unsigned divisor, captured when start is accepted.
REQ-009 SHALL have busy  output  1  high from the cycle after acceptance until done is asserted.
REQ-010 SHALL have done  output  1  one-cycle pulse marking valid results.
REQ-011 SHALL have quotient  output  N_WIDTH  unsigned quotient.
REQ-012 SHALL have remainder  output  D_WIDTH  unsigned remainder.
REQ-013 SHALL have div_by_zero  output  1  set with done when the captured divisor is 0.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN and DONE; the reset state is IDLE.
REQ-015 SHALL accept start only in IDLE; on the accepting edge it captures the operands, clears the 5-bit step counter and the partial remainder, then enters RUN, or DONE if divisor==0.
REQ-016 SHALL perform one restoring step per RUN cycle: shift in the next dividend bit (MSB first) and compare it against the divisor over a (D_WIDTH+1)-bit partial remainder; if not negative, subtract and set the quotient bit to 1, otherwise restore and set it to 0.
REQ-017 SHALL stay in RUN for exactly N_WIDTH cycles; on the last step the counter goes from 31 to DONE with no wrap-around reuse.
REQ-018 SHALL have a latency of start-accept edge to done high of N_WIDTH+1 cycles (33) for a nonzero divisor, and 1 cycle for a zero divisor.
REQ-019 SHALL hold done high for exactly one cycle in DONE, then return to IDLE.
REQ-020 SHALL hold quotient, remainder and div_by_zero from done until the next accepted start, where all three update only at the next done.
REQ-021 SHALL produce, on divide by zero, quotient = all ones, remainder = dividend[D_WIDTH-1:0] and div_by_zero = 1.
REQ-022 SHALL ignore start in RUN and DONE: no recapture and no restart.
REQ-023 SHALL, when start is high in the IDLE cycle immediately following DONE, accept it (back-to-back operation is allowed).
REQ-024 SHALL satisfy quotient*divisor + remainder == dividend, with remainder < divisor, for all nonzero divisors.

Reset
REQ-025 SHALL, while rst is high at a clock edge, force state=IDLE, busy=0, done=0, div_by_zero=0, quotient=0, remainder=0 and counter=0.
REQ-026 SHALL, on rst asserted mid-RUN, abandon the operation with no done pulse; the first start after rst deasserts is handled normally.
REQ-027 SHALL give rst priority over start in the same cycle.

Structure
REQ-028 SHALL define the state encoding (IDLE/RUN/DONE), N_WIDTH/D_WIDTH defaults and the counter width in a shared package, divider_pkg.
REQ-029 SHALL use one combinational sub-module, div_step (shift, trial subtract, restore, quotient bit); the FSM, counter and registers stay in the top module.
REQ-030 SHALL avoid any use of a combinational divide operator.

Verification
REQ-031 SHALL cover 75 / 5 -> quotient 15, remainder 0, done 33 cycles after start.
REQ-032 SHALL cover 1000000/1000 -> 1000 r 0; 959904/9999 -> 96 r 0; 256000/250 -> 1024 r 0; 3322/255 -> 13 r 7, run back-to-back with start held in the IDLE cycle after each done.
REQ-033 SHALL cover 32'hFFFFFFFF / 1 -> quotient FFFFFFFF, remainder 0; 5 / 7 -> quotient 0, remainder 5.
REQ-034 SHALL cover 1234 / 0 -> done 1 cycle after start, div_by_zero=1, quotient FFFFFFFF, remainder 1234.
REQ-035 SHALL cover start pulsed with new operands at RUN cycle 10 -> ignored, and the original result is delivered at cycle 33.
REQ-036 SHALL cover rst at RUN cycle 15 -> all outputs 0, no done; a subsequent 100/7 -> 14 r 2.
